// File: rtl/vram_if.sv
// Bus bundle between the tile renderer, CPU, video RAM and the
// VRAM responder.
interface vram_if;
  logic [15:0] tile_RAM_addr;
  logic [15:0] palette_RAM_addr;
  logic [7:0]  tile_ROM_addr;
  logic [5:0]  palette_ROM_addr;
  logic        fetch_done;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        ram_en;
  logic        ram_we;
  logic [10:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  modport slave (
    input  tile_RAM_addr,
    input  palette_RAM_addr,
    output tile_ROM_addr,
    output palette_ROM_addr,
    output fetch_done,
    input  cpu_req,
    input  cpu_we,
    input  cpu_addr,
    input  cpu_wdata,
    output cpu_ack,
    output cpu_rdata,
    output ram_en,
    output ram_we,
    output ram_addr,
    output ram_wdata,
    input  ram_rdata
  );

  modport master (
    output tile_RAM_addr,
    output palette_RAM_addr,
    input  tile_ROM_addr,
    input  palette_ROM_addr,
    input  fetch_done,
    output cpu_req,
    output cpu_we,
    output cpu_addr,
    output cpu_wdata,
    input  cpu_ack,
    input  cpu_rdata,
    input  ram_en,
    input  ram_we,
    input  ram_addr,
    input  ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/vram_responder.sv
// Video RAM responder: 4-slot schedule sharing one RAM port between
// tile fetch (slot 0), palette fetch (slot 1) and one CPU access (slot 2).
module vram_responder (
  input logic  clk,
  input logic  rst,
  vram_if.slave bus
);

  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;

  phase_t      phase;
  logic        tile_hit_q;
  logic [15:0] pal_addr_q;
  logic [7:0]  tile_stage;
  logic [7:0]  tile_out;
  logic [5:0]  pal_out;
  logic        fetch_q;
  logic        ack_q;
  logic        cpu_rd_q;
  logic [7:0]  rdata_hold;
  logic [7:0]  cpu_rdata_c;

  logic tile_hit;
  logic pal_hit;
  logic cpu_hit;
  logic accept;

  assign tile_hit = (bus.tile_RAM_addr[15:10] == 6'h10);
  assign pal_hit  = (pal_addr_q[15:10] == 6'h11);
  assign cpu_hit  = (bus.cpu_addr[15:11] == 5'h08);
  assign accept   = rst && (phase == PH2) && bus.cpu_req;

  // RAM port is steered combinationally so reset can veto a slot-2 write.
  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = 11'd0;
    bus.ram_wdata = 8'd0;
    if (rst) begin
      unique case (phase)
        PH0: if (tile_hit) begin
          bus.ram_en   = 1'b1;
          bus.ram_addr = bus.tile_RAM_addr[10:0];
        end
        PH1: if (pal_hit) begin
          bus.ram_en   = 1'b1;
          bus.ram_addr = pal_addr_q[10:0];
        end
        PH2: if (accept && cpu_hit) begin
          bus.ram_en    = 1'b1;
          bus.ram_we    = bus.cpu_we;
          bus.ram_addr  = bus.cpu_addr[10:0];
          bus.ram_wdata = bus.cpu_wdata;
        end
        PH3: ;
      endcase
    end
  end

  // Read data arrives in the ack cycle; it is then held until the next ack.
  always_comb begin
    cpu_rdata_c = rdata_hold;
    if (ack_q)
      cpu_rdata_c = cpu_rd_q ? bus.ram_rdata : 8'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase      <= PH0;
      tile_hit_q <= 1'b0;
      pal_addr_q <= 16'd0;
      tile_stage <= 8'd0;
      tile_out   <= 8'd0;
      pal_out    <= 6'd0;
      fetch_q    <= 1'b0;
      ack_q      <= 1'b0;
      cpu_rd_q   <= 1'b0;
      rdata_hold <= 8'd0;
    end else begin
      phase    <= phase_t'(phase + 2'd1);
      fetch_q  <= (phase == PH2);
      ack_q    <= accept;
      cpu_rd_q <= accept && cpu_hit && !bus.cpu_we;
      if (ack_q)
        rdata_hold <= cpu_rdata_c;
      unique case (phase)
        PH0: begin
          tile_hit_q <= tile_hit;
          pal_addr_q <= bus.palette_RAM_addr;
        end
        PH1: tile_stage <= tile_hit_q ? bus.ram_rdata : 8'd0;
        PH2: begin
          tile_out <= tile_stage;
          pal_out  <= pal_hit ? bus.ram_rdata[5:0] : 6'd0;
        end
        PH3: ;
      endcase
    end
  end

  assign bus.tile_ROM_addr    = tile_out;
  assign bus.palette_ROM_addr = pal_out;
  assign bus.fetch_done       = fetch_q;
  assign bus.cpu_ack          = ack_q;
  assign bus.cpu_rdata        = cpu_rdata_c;

endmodule
